// File: rtl/demux_pkg.sv
// Shared defaults and select encodings for the 1-to-2 buffered demultiplexer.
package demux_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 2;

    typedef enum logic {
        SEL_OUT0 = 1'b0,
        SEL_OUT1 = 1'b1
    } sel_e;

endpackage

// File: rtl/demux1to2_width32_fifo_sync.sv
// Single-clock FIFO with occupancy count; head word reads as zero while empty.
module fifo_sync #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/demux1to2_width32.sv
// Routes each accepted input word into one of two output FIFOs selected by in_sel.
module demux1to2_width32
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    output logic                   out0_valid,
    input  logic                   out0_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic [$clog2(DEPTH):0] out0_count,
    output logic                   out1_valid,
    input  logic                   out1_ready,
    output logic [WIDTH-1:0]       out1_data,
    output logic [$clog2(DEPTH):0] out1_count
);

    logic full0, full1;
    logic empty0, empty1;
    logic route1;
    logic push0, push1;

    // Anything other than a definite 1 (including X/Z) falls to out0.
    always_comb begin
        route1 = 1'b0;
        case (in_sel)
            SEL_OUT1: route1 = 1'b1;
            default:  route1 = 1'b0;
        endcase
    end

    always_comb begin
        in_ready = route1 ? !full1 : !full0;
        push0    = in_valid && in_ready && !route1;
        push1    = in_valid && in_ready &&  route1;
    end

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .wdata (in_data),
        .pop   (out0_ready),
        .rdata (out0_data),
        .full  (full0),
        .empty (empty0),
        .count (out0_count)
    );

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .wdata (in_data),
        .pop   (out1_ready),
        .rdata (out1_data),
        .full  (full1),
        .empty (empty1),
        .count (out1_count)
    );

    assign out0_valid = !empty0;
    assign out1_valid = !empty1;

endmodule
